pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports id_valid, id_rn_used and id_rm_used, input, 1 bit each: decode slot valid and which source fields it reads.
REQ-004 SHALL have ports id_rn and id_rm, input, `REGAW bits each: decode source register numbers.
REQ-005 SHALL have ports ex_valid, ex_wr and ex_is_load, input, 1 bit each: execute slot valid, writes a register, is an LDR.
REQ-006 SHALL have port ex_rd, input, `REGAW bits: execute destination register.
REQ-007 SHALL have port ex_alu_opcode, input, `ALUAW bits: execute ALU opcode.
REQ-008 SHALL have port ex_branch_taken, input, 1 bit: execute resolved a taken branch.
REQ-009 SHALL have port mem_done, input, 1 bit: data memory completes the outstanding load this cycle.
REQ-010 SHALL have ports stall_if and stall_id, output, 1 bit each: hold the PC and the IF/ID register.
REQ-011 SHALL have port bubble_ex, output, 1 bit: inject a NOP into ID/EX.
REQ-012 SHALL have port flush, output, 1 bit: squash IF and ID contents.
REQ-013 SHALL have ports fwd_rn and fwd_rm, output, 1 bit each: select the EX result for that source.
REQ-014 SHALL have port stall_cycles, output, 16 bits: saturating count of cycles with stall_id high.

Function
REQ-015 SHALL implement a state machine with states RUN, MEM_WAIT and FLUSH2.
- Outputs are combinational from state and inputs.
- stall_cycles is registered.
REQ-016 SHALL detect a hit on a source field (rn or rm) as: id_valid & id_x_used & ex_valid & ex_wr & (id_x == ex_rd).
REQ-017 SHALL, in RUN, assert fwd_x for a hit when ex_is_load=0 and ex_alu_opcode is not TST, TEQ, CMP or CMN.
REQ-018 SHALL, in RUN, treat a hit with ex_is_load=1 as a load-use hazard.
- That cycle: stall_if=stall_id=bubble_ex=1.
- fwd_rn=fwd_rm=0.
REQ-019 SHALL, in RUN, set next state MEM_WAIT when ex_valid & ex_is_load and no flush is asserted this cycle.
REQ-020 SHALL, in MEM_WAIT, assert stall_if=stall_id=bubble_ex=1 and fwd_*=0 until mem_done.
- mem_done=1 returns the block to RUN the next cycle.
- On that mem_done cycle the stall outputs are still asserted.
REQ-021 SHALL, in RUN, handle ex_valid & ex_branch_taken as follows.
- Assert flush=1 and fwd_*=0.
- Suppress stall/bubble outputs (branch has priority over load-use).
- Next state FLUSH2.
REQ-022 SHALL, in FLUSH2, assert flush=1 for exactly one cycle, then go to RUN.
- All other outputs 0.
- Total branch penalty is 2 cycles.
REQ-023 SHALL ignore ex_branch_taken and ex_is_load while in MEM_WAIT or FLUSH2.
REQ-024 SHALL compare ex_rd against register 15 (PC) like any other register; no special case.
REQ-025 SHALL increment stall_cycles on every cycle stall_id=1 and saturate at 16'hFFFF.
REQ-026 SHALL, when id_valid=0 or ex_valid=0, produce no hit, forward or load-use stall from that slot.

Reset
REQ-027 SHALL, while reset=1, force state RUN and stall_cycles=0.
- All outputs 0 in that cycle regardless of other inputs.
REQ-028 SHALL, on reset asserted mid-MEM_WAIT or mid-FLUSH2, abandon the operation and resume RUN on the next cycle.
- A later mem_done is ignored.

Structure
REQ-029 SHALL take `REGAW, `ALUAW and the TST/TEQ/CMP/CMN opcode constants from the shared defines.v.
- The state encodings (2 bits) are also added there.
REQ-030 SHALL contain one sub-module, src_hit, instantiated once per source field.
- It computes the hit and forwardable flags for that field.

Verification
REQ-031 SHALL cover: ex ADD rd=3 valid, id rn=3 used -> fwd_rn=1, no stall.
REQ-032 SHALL cover: ex CMP rd=3, id rn=3 -> fwd_rn=0, no stall.
REQ-033 SHALL cover: ex LDR rd=5, id rm=5, mem_done low 3 cycles then high.
- Stall/bubble high 1 (RUN) + 4 (MEM_WAIT) cycles.
- stall_cycles=5.
- RUN afterwards.
REQ-034 SHALL cover: ex_branch_taken=1 together with a load-use hit.
- flush high 2 consecutive cycles.
- stall/bubble stay 0.
- Then RUN.
REQ-035 SHALL cover: reset pulsed in the 2nd MEM_WAIT cycle.
- Outputs 0 during reset, RUN after.
- A mem_done pulse afterwards has no effect.
REQ-036 SHALL cover: stall_cycles preloaded to 16'hFFFE via a long stall.
- After 3 more stall cycles it reads 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared widths, opcode constants and FSM encoding for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int unsigned RegAw = 4;
    localparam int unsigned AluAw = 4;

    localparam logic [AluAw-1:0] OpTst = 4'h8;
    localparam logic [AluAw-1:0] OpTeq = 4'h9;
    localparam logic [AluAw-1:0] OpCmp = 4'hA;
    localparam logic [AluAw-1:0] OpCmn = 4'hB;

    localparam logic [15:0] StallCntMax = 16'hFFFF;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush2  = 2'd2
    } state_e;

    // Compare-class ops set flags only, so they never produce a register result to forward.
    function automatic logic is_compare(input logic [AluAw-1:0] op);
        logic res;
        case (op)
            OpTst, OpTeq, OpCmp, OpCmn: res = 1'b1;
            default:                    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/src_hit.sv
// Per-source-field dependency check against the instruction in EX.
module src_hit
    import pipeline_ctrl_pkg::*;
(
    input  logic             id_valid_i,
    input  logic             used_i,
    input  logic [RegAw-1:0] reg_i,
    input  logic             ex_valid_i,
    input  logic             ex_wr_i,
    input  logic             ex_is_load_i,
    input  logic [RegAw-1:0] ex_rd_i,
    input  logic [AluAw-1:0] ex_alu_opcode_i,
    output logic             hit_o,
    output logic             fwd_ok_o
);

    always_comb begin
        hit_o    = id_valid_i & used_i & ex_valid_i & ex_wr_i & (reg_i == ex_rd_i);
        fwd_ok_o = hit_o & ~ex_is_load_i & ~is_compare(ex_alu_opcode_i);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: forwarding selects, load-use stalls, load wait and two-cycle branch flush.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [RegAw-1:0] id_rn,
    input  logic [RegAw-1:0] id_rm,
    input  logic             ex_valid,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic [RegAw-1:0] ex_rd,
    input  logic [AluAw-1:0] ex_alu_opcode,
    input  logic             ex_branch_taken,
    input  logic             mem_done,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic             fwd_rn,
    output logic             fwd_rm,
    output logic [15:0]      stall_cycles
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hit_rn, hit_rm, fwd_ok_rn, fwd_ok_rm;
    logic        load_use;

    src_hit u_hit_rn (
        .id_valid_i      (id_valid),
        .used_i          (id_rn_used),
        .reg_i           (id_rn),
        .ex_valid_i      (ex_valid),
        .ex_wr_i         (ex_wr),
        .ex_is_load_i    (ex_is_load),
        .ex_rd_i         (ex_rd),
        .ex_alu_opcode_i (ex_alu_opcode),
        .hit_o           (hit_rn),
        .fwd_ok_o        (fwd_ok_rn)
    );

    src_hit u_hit_rm (
        .id_valid_i      (id_valid),
        .used_i          (id_rm_used),
        .reg_i           (id_rm),
        .ex_valid_i      (ex_valid),
        .ex_wr_i         (ex_wr),
        .ex_is_load_i    (ex_is_load),
        .ex_rd_i         (ex_rd),
        .ex_alu_opcode_i (ex_alu_opcode),
        .hit_o           (hit_rm),
        .fwd_ok_o        (fwd_ok_rm)
    );

    assign load_use = (hit_rn | hit_rm) & ex_is_load;

    always_comb begin
        state_d   = state_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        fwd_rn    = 1'b0;
        fwd_rm    = 1'b0;
        case (state_q)
            StRun: begin
                // A taken branch wins over any load-use stall in the same cycle.
                if (ex_valid && ex_branch_taken) begin
                    flush   = 1'b1;
                    state_d = StFlush2;
                end else begin
                    if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        fwd_rn = fwd_ok_rn;
                        fwd_rm = fwd_ok_rm;
                    end
                    if (ex_valid && ex_is_load) begin
                        state_d = StMemWait;
                    end
                end
            end
            StMemWait: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                if (mem_done) begin
                    state_d = StRun;
                end
            end
            StFlush2: begin
                flush   = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
        if (reset) begin
            state_d   = StRun;
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            bubble_ex = 1'b0;
            flush     = 1'b0;
            fwd_rn    = 1'b0;
            fwd_rm    = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && (cnt_q != StallCntMax)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected outputs queued per driven cycle, checked at negedge.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam logic [AluAw-1:0] OpAdd = 4'h4;
    localparam logic [AluAw-1:0] OpSub = 4'h2;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_rn_used, id_rm_used;
    logic [RegAw-1:0] id_rn, id_rm;
    logic             ex_valid, ex_wr, ex_is_load;
    logic [RegAw-1:0] ex_rd;
    logic [AluAw-1:0] ex_alu_opcode;
    logic             ex_branch_taken, mem_done;
    logic             stall_if, stall_id, bubble_ex, flush, fwd_rn, fwd_rm;
    logic [15:0]      stall_cycles;

    pipeline_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rn_used      (id_rn_used),
        .id_rm_used      (id_rm_used),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .ex_valid        (ex_valid),
        .ex_wr           (ex_wr),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_alu_opcode   (ex_alu_opcode),
        .ex_branch_taken (ex_branch_taken),
        .mem_done        (mem_done),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush           (flush),
        .fwd_rn          (fwd_rn),
        .fwd_rm          (fwd_rm),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // Output vector order: {stall_if, stall_id, bubble_ex, flush, fwd_rn, fwd_rm}
    localparam logic [5:0] ONone  = 6'b000000;
    localparam logic [5:0] OStall = 6'b111000;
    localparam logic [5:0] OFlush = 6'b000100;
    localparam logic [5:0] OFwdN  = 6'b000010;
    localparam logic [5:0] OFwdNM = 6'b000011;

    typedef struct packed {
        logic [5:0]  outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: queue expectation, compare at negedge, then advance the counter model.
    task automatic step(input string tag, input logic [5:0] outs);
        exp_t e;
        sb_q.push_back('{outs: outs, cnt: exp_cnt});
        @(negedge clk);
        e = sb_q.pop_front();
        check({tag, "_outs"}, {26'd0, stall_if, stall_id, bubble_ex, flush, fwd_rn, fwd_rm},
              {26'd0, e.outs});
        check({tag, "_cnt"}, {16'd0, stall_cycles}, {16'd0, e.cnt});
        if (reset) exp_cnt = 16'd0;
        else if (e.outs[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic wr, input logic ld, input logic [3:0] rd,
                          input logic [3:0] op, input logic br);
        ex_valid = v; ex_wr = wr; ex_is_load = ld; ex_rd = rd;
        ex_alu_opcode = op; ex_branch_taken = br;
    endtask

    task automatic set_id(input logic v, input logic rnu, input logic [3:0] rn,
                          input logic rmu, input logic [3:0] rm);
        id_valid = v; id_rn_used = rnu; id_rn = rn; id_rm_used = rmu; id_rm = rm;
    endtask

    initial begin
        logic [3:0] cmp_ops [4];
        cmp_ops[0] = OpTst; cmp_ops[1] = OpTeq; cmp_ops[2] = OpCmp; cmp_ops[3] = OpCmn;

        reset = 1'b1; mem_done = 1'b0;
        set_ex(1, 1, 1, 4'd5, OpAdd, 1);
        set_id(1, 1, 4'd5, 1, 4'd5);
        @(posedge clk); #1;
        step("reset", ONone);
        reset = 1'b0;

        // Forwarding from ALU results
        set_ex(1, 1, 0, 4'd3, OpAdd, 0); set_id(1, 1, 4'd3, 0, 4'd0);
        step("fwd_add_rn", OFwdN);
        set_id(1, 1, 4'd3, 1, 4'd3);
        step("fwd_add_both", OFwdNM);
        set_ex(1, 1, 0, 4'd15, OpSub, 0); set_id(1, 0, 4'd0, 1, 4'd15);
        step("fwd_pc_rm", 6'b000001);
        set_ex(1, 1, 0, 4'd3, OpAdd, 0); set_id(1, 1, 4'd4, 1, 4'd2);
        step("no_match", ONone);
        set_ex(1, 0, 0, 4'd3, OpAdd, 0); set_id(1, 1, 4'd3, 0, 4'd0);
        step("no_wr", ONone);
        set_ex(1, 1, 0, 4'd3, OpAdd, 0); set_id(0, 1, 4'd3, 1, 4'd3);
        step("id_invalid", ONone);
        set_ex(0, 1, 1, 4'd3, OpAdd, 0); set_id(1, 1, 4'd3, 1, 4'd3);
        step("ex_invalid", ONone);
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 1, 0, 4'd3, cmp_ops[i], 0); set_id(1, 1, 4'd3, 0, 4'd0);
            step($sformatf("cmp_op%0d", i), ONone);
        end

        // Load-use on rm, memory takes 4 MEM_WAIT cycles; branch ignored while waiting
        reset = 1'b1; step("rst2", ONone); reset = 1'b0;
        set_ex(1, 1, 1, 4'd5, OpAdd, 0); set_id(1, 0, 4'd0, 1, 4'd5);
        step("ldu_run", OStall);
        set_ex(1, 1, 1, 4'd7, OpAdd, 1);
        for (int i = 0; i < 3; i++) step($sformatf("memwait%0d", i), OStall);
        mem_done = 1'b1;
        step("memwait_done", OStall);
        mem_done = 1'b0; set_ex(0, 0, 0, 4'd0, OpAdd, 0); set_id(0, 0, 4'd0, 0, 4'd0);
        step("after_load", ONone);
        check("ldu_total", {16'd0, stall_cycles}, 32'd5);
        set_ex(1, 1, 0, 4'd1, OpAdd, 0); set_id(1, 1, 4'd1, 0, 4'd0);
        step("run_again", OFwdN);

        // Branch with simultaneous load-use hit: two flush cycles, no stall
        set_ex(1, 1, 1, 4'd5, OpAdd, 1); set_id(1, 0, 4'd0, 1, 4'd5);
        step("br_run", OFlush);
        step("br_flush2", OFlush);
        set_ex(1, 1, 0, 4'd2, OpAdd, 0); set_id(1, 1, 4'd2, 0, 4'd0);
        step("br_after", OFwdN);

        // Reset in the 2nd MEM_WAIT cycle
        set_ex(1, 1, 1, 4'd6, OpAdd, 0); set_id(1, 0, 4'd0, 0, 4'd0);
        step("ld_nohit", ONone);
        step("mw1", OStall);
        reset = 1'b1;
        step("mw2_reset", ONone);
        reset = 1'b0; set_ex(0, 0, 0, 4'd0, OpAdd, 0); mem_done = 1'b1;
        step("post_rst_done", ONone);
        mem_done = 1'b0; set_ex(1, 1, 0, 4'd8, OpAdd, 0); set_id(1, 1, 4'd8, 1, 4'd8);
        step("post_rst_run", OFwdNM);

        // Reset in FLUSH2
        set_ex(1, 0, 0, 4'd0, OpAdd, 1); set_id(0, 0, 4'd0, 0, 4'd0);
        step("br2_run", OFlush);
        reset = 1'b1;
        step("fl2_reset", ONone);
        reset = 1'b0; set_ex(0, 0, 0, 4'd0, OpAdd, 0);
        step("post_fl_rst", ONone);

        // Saturation: long MEM_WAIT stall to 16'hFFFE, then 3 more stall cycles
        set_ex(1, 1, 1, 4'd9, OpAdd, 0);
        step("sat_enter", ONone);
        set_ex(0, 0, 0, 4'd0, OpAdd, 0);
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk); #1;
            exp_cnt = exp_cnt + 16'd1;
        end
        step("sat_fffe", OStall);
        step("sat_1", OStall);
        mem_done = 1'b1;
        step("sat_2", OStall);
        mem_done = 1'b0;
        step("sat_after", ONone);
        check("sat_final", {16'd0, stall_cycles}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
